// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl
//   Data memory for the MEM stage of the pipelined MIPS datapath. Supports
//   byte/half/word stores and loads (sign or zero extended), registered reads
//   with a one-cycle valid strobe, alignment and range checking, and an
//   optional post-reset clear engine that holds ready low while every word is
//   zeroed.
//
// Ports
//   clk          : clock, rising edge
//   reset        : asynchronous active-low reset
//   memRead      : load request
//   memWrite     : store request
//   size         : 00 byte, 01 half, 10/11 word
//   unsignedLoad : 1 = zero-extend sub-word loads, 0 = sign-extend
//   address      : byte address (word index = address[31:2])
//   writeData    : store data, byte/half taken from the low bits
//   readData     : registered load result
//   readValid    : one-cycle pulse, readData holds a new load result
//   ready        : 1 when requests are accepted, 0 while clearing
//   misaligned   : one-cycle pulse, previous request was misaligned
//   outOfRange   : one-cycle pulse, previous request addressed word >= DEPTH
//
// Handshake: there is no back-pressure inside RUN. A request is any cycle with
// memRead | memWrite while ready = 1; it is consumed at that rising edge, and
// its result (readValid / misaligned / outOfRange) is visible in the next
// cycle. Requests presented while ready = 0 are dropped without any flag.
module data_memory_ctrl #(
  parameter int DEPTH          = 256,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  size,
  input  logic        unsignedLoad,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        readValid,
  output logic        ready,
  output logic        misaligned,
  output logic        outOfRange
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q;
  logic [31:0]     mem [DEPTH];

  logic [1:0]      lane;
  logic [AW-1:0]   idx;
  logic            req;
  logic            mis_hit;
  logic            oor_hit;
  logic [31:0]     rd_word;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [31:0]     ld_val;

  logic            we;
  logic [3:0]      be;
  logic [31:0]     wdata;
  logic [AW-1:0]   widx;
  logic            load_ok;
  logic            load_oor;
  logic            set_mis;
  logic            set_oor;

  assign lane    = address[1:0];
  assign idx     = address[AW+1:2];
  assign req     = memRead | memWrite;
  // Any set bit above the implemented index bits means word index >= DEPTH.
  assign oor_hit = |address[31:AW+2];
  assign ready   = (state_q == S_RUN);

  always_comb begin
    mis_hit = 1'b0;
    case (size)
      2'b00:   mis_hit = 1'b0;
      2'b01:   mis_hit = address[0];
      default: mis_hit = |address[1:0];
    endcase
  end

  // Load path reads the pre-edge contents, which gives read-before-write when
  // a load and store to the same word share a cycle.
  assign rd_word = mem[idx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = address[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_val = rd_word;
    case (size)
      2'b00:   ld_val = {{24{~unsignedLoad & rd_byte[7]}}, rd_byte};
      2'b01:   ld_val = {{16{~unsignedLoad & rd_half[15]}}, rd_half};
      default: ld_val = rd_word;
    endcase
  end

  // Next-state and request decode.
  always_comb begin
    state_d  = state_q;
    we       = 1'b0;
    be       = 4'b0000;
    wdata    = 32'h0;
    widx     = idx;
    load_ok  = 1'b0;
    load_oor = 1'b0;
    set_mis  = 1'b0;
    set_oor  = 1'b0;
    case (state_q)
      S_CLEAR: begin
        we   = 1'b1;
        be   = 4'b1111;
        widx = clr_cnt_q;
        if (clr_cnt_q == LAST_IDX) state_d = S_RUN;
      end
      S_RUN: begin
        if (req) begin
          if (mis_hit) begin
            set_mis = 1'b1;
          end else if (oor_hit) begin
            set_oor  = 1'b1;
            load_oor = memRead;
          end else begin
            load_ok = memRead;
            if (memWrite) begin
              we = 1'b1;
              case (size)
                2'b00: begin
                  be    = 4'b0001 << lane;
                  wdata = {4{writeData[7:0]}};
                end
                2'b01: begin
                  be    = address[1] ? 4'b1100 : 4'b0011;
                  wdata = {2{writeData[15:0]}};
                end
                default: begin
                  be    = 4'b1111;
                  wdata = writeData;
                end
              endcase
            end
          end
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
      clr_cnt_q  <= '0;
      readData   <= 32'h0;
      readValid  <= 1'b0;
      misaligned <= 1'b0;
      outOfRange <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= (state_q == S_CLEAR) ? clr_cnt_q + 1'b1 : '0;
      readValid  <= load_ok | load_oor;
      misaligned <= set_mis;
      outOfRange <= set_oor;
      if (load_ok)       readData <= ld_val;
      else if (load_oor) readData <= 32'h0;
    end
  end

  // Storage array carries no reset; byte enables keep untouched lanes intact.
  always_ff @(posedge clk) begin
    if (we && reset) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
module tb_data_memory_ctrl;

  localparam logic [1:0] SB = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SW = 2'b10;
  localparam logic [1:0] SX = 2'b11;
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a;
    logic [31:0] wd;
    logic        v;
    logic        m;
    logic        o;
    logic [31:0] d;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst16 = 1'b0;
  logic        mem_rd = 1'b0, mem_wr = 1'b0, uns = 1'b0;
  logic [1:0]  sz = 2'b00;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [31:0] rd_data;
  logic        rd_valid, rdy, mis, oor;

  logic        rst64 = 1'b0;
  logic        mem_rd64 = 1'b0;
  logic [31:0] rd_data64;
  logic        rd_valid64, rdy64, mis64, oor64;

  data_memory_ctrl #(.DEPTH(16), .CLEAR_ON_RESET(1'b1)) dut16 (
    .clk(clk), .reset(rst16), .memRead(mem_rd), .memWrite(mem_wr), .size(sz),
    .unsignedLoad(uns), .address(addr), .writeData(wdata), .readData(rd_data),
    .readValid(rd_valid), .ready(rdy), .misaligned(mis), .outOfRange(oor)
  );

  data_memory_ctrl #(.DEPTH(64), .CLEAR_ON_RESET(1'b1)) dut64 (
    .clk(clk), .reset(rst64), .memRead(mem_rd64), .memWrite(1'b0), .size(SW),
    .unsignedLoad(1'b0), .address(32'h0), .writeData(32'h0), .readData(rd_data64),
    .readValid(rd_valid64), .ready(rdy64), .misaligned(mis64), .outOfRange(oor64)
  );

  // ---------------- scoreboard ----------------
  logic [34:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] s,
                              input logic u, input logic [31:0] a, input logic [31:0] wd,
                              input logic v, input logic m, input logic o,
                              input logic [31:0] d);
    vec_t t;
    t.rd = rd; t.wr = wr; t.sz = s; t.u = u; t.a = a; t.wd = wd;
    t.v = v; t.m = m; t.o = o; t.d = d;
    return t;
  endfunction

  // ---------------- driver ----------------
  // Drives one request for one edge, records its expected result, and
  // returns #1 after the edge with the inputs idle.
  task automatic issue(input vec_t t);
    mem_rd = t.rd; mem_wr = t.wr; sz = t.sz; uns = t.u; addr = t.a; wdata = t.wd;
    exp_q.push_back({t.v, t.m, t.o, t.d});
    @(posedge clk); #1;
    mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [35:0] got;
    #3;
    got = {rdy, rd_valid, mis, oor, rd_data};
    n_checks++;
    if (got !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h", got, 36'h0);
    end
    // Hold a misaligned request through the clear; it must be ignored.
    mem_rd = 1'b1; sz = SH; addr = 32'h13;
    @(negedge clk); rst16 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      got = {32'h0, rdy, rd_valid, mis, oor};
      n_checks++;
      if (got !== {32'h0, (i == 16), 3'b000}) begin
        n_fail++;
        $display("FAIL clear_cycle_%0d: got %h expected %h", i, got, {32'h0, (i == 16), 3'b000});
      end
    end
    mem_rd = 1'b0;
  endtask

  task automatic test_clear_contents;
    vec_t vs[$];
    logic [34:0] e, got;
    vs.push_back(mk(Y, N, SW, N, 32'h3C, 32'h0, Y, N, N, 32'h0));
    vs.push_back(mk(Y, N, SW, N, 32'h00, 32'h0, Y, N, N, 32'h0));
    foreach (vs[k]) begin
      issue(vs[k]);
      got = {rd_valid, mis, oor, rd_data};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL clear_contents[%0d]: got %h expected %h", k, got, e);
      end
    end
  endtask

  task automatic test_subword;
    vec_t vs[$];
    logic [34:0] e, got;
    vs.push_back(mk(N, Y, SW, N, 32'h10, 32'h11223344, N, N, N, 32'h0));
    vs.push_back(mk(N, Y, SB, N, 32'h11, 32'h000000AA, N, N, N, 32'h0));
    vs.push_back(mk(Y, N, SW, N, 32'h10, 32'h0, Y, N, N, 32'h1122AA44));
    vs.push_back(mk(Y, N, SB, N, 32'h11, 32'h0, Y, N, N, 32'hFFFFFFAA));
    vs.push_back(mk(Y, N, SB, Y, 32'h11, 32'h0, Y, N, N, 32'h000000AA));
    vs.push_back(mk(Y, N, SH, N, 32'h12, 32'h0, Y, N, N, 32'h00001122));
    vs.push_back(mk(N, Y, SH, N, 32'h14, 32'hFFFF8001, N, N, N, 32'h00001122));
    vs.push_back(mk(Y, N, SH, N, 32'h14, 32'h0, Y, N, N, 32'hFFFF8001));
    vs.push_back(mk(Y, N, SH, Y, 32'h14, 32'h0, Y, N, N, 32'h00008001));
    vs.push_back(mk(Y, N, SB, N, 32'h13, 32'h0, Y, N, N, 32'h00000011));
    vs.push_back(mk(Y, N, SX, Y, 32'h10, 32'h0, Y, N, N, 32'h1122AA44));
    foreach (vs[k]) begin
      issue(vs[k]);
      got = {rd_valid, mis, oor, rd_data};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL subword[%0d]: got %h expected %h", k, got, e);
      end
    end
  endtask

  task automatic test_alignment;
    vec_t vs[$];
    logic [34:0] e, got;
    vs.push_back(mk(Y, N, SH, N, 32'h13, 32'h0, N, Y, N, 32'h1122AA44));
    vs.push_back(mk(N, Y, SW, N, 32'h16, 32'hDEADBEEF, N, Y, N, 32'h1122AA44));
    vs.push_back(mk(N, Y, SH, N, 32'h15, 32'h0000BEEF, N, Y, N, 32'h1122AA44));
    vs.push_back(mk(Y, N, SX, N, 32'h12, 32'h0, N, Y, N, 32'h1122AA44));
    vs.push_back(mk(Y, N, SW, N, 32'h14, 32'h0, Y, N, N, 32'h00008001));
    vs.push_back(mk(Y, N, SB, N, 32'h17, 32'h0, Y, N, N, 32'h00000000));
    foreach (vs[k]) begin
      issue(vs[k]);
      got = {rd_valid, mis, oor, rd_data};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL alignment[%0d]: got %h expected %h", k, got, e);
      end
    end
  endtask

  task automatic test_range;
    vec_t vs[$];
    logic [34:0] e, got;
    vs.push_back(mk(Y, N, SW, N, 32'h14, 32'h0, Y, N, N, 32'h00008001));
    vs.push_back(mk(N, Y, SW, N, 32'h40, 32'h12345678, N, N, Y, 32'h00008001));
    vs.push_back(mk(Y, N, SW, N, 32'h00, 32'h0, Y, N, N, 32'h0));
    vs.push_back(mk(Y, N, SW, N, 32'h14, 32'h0, Y, N, N, 32'h00008001));
    vs.push_back(mk(Y, N, SW, N, 32'h40, 32'h0, Y, N, Y, 32'h0));
    vs.push_back(mk(Y, N, SH, N, 32'h41, 32'h0, N, Y, N, 32'h0));
    vs.push_back(mk(N, Y, SB, N, 32'h80000003, 32'h55, N, N, Y, 32'h0));
    vs.push_back(mk(Y, N, SW, N, 32'h00, 32'h0, Y, N, N, 32'h0));
    foreach (vs[k]) begin
      issue(vs[k]);
      got = {rd_valid, mis, oor, rd_data};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL range[%0d]: got %h expected %h", k, got, e);
      end
    end
  endtask

  task automatic test_read_before_write;
    vec_t vs[$];
    logic [34:0] e, got;
    vs.push_back(mk(N, Y, SW, N, 32'h20, 32'h5, N, N, N, 32'h0));
    vs.push_back(mk(Y, Y, SW, N, 32'h20, 32'h9, Y, N, N, 32'h5));
    vs.push_back(mk(Y, N, SW, N, 32'h20, 32'h0, Y, N, N, 32'h9));
    vs.push_back(mk(N, N, SW, N, 32'h20, 32'h0, N, N, N, 32'h9));
    foreach (vs[k]) begin
      issue(vs[k]);
      got = {rd_valid, mis, oor, rd_data};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL rbw[%0d]: got %h expected %h", k, got, e);
      end
    end
  endtask

  // Random word traffic on words 8..15, one request per cycle.
  task automatic test_back_to_back;
    logic [31:0] model [16];
    logic [31:0] last, d;
    logic [34:0] e, got;
    int w;
    bit is_rd;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    model[8] = 32'h9;
    last = 32'h9;
    for (int k = 0; k < 40; k++) begin
      w     = $urandom_range(8, 15);
      is_rd = ($urandom_range(0, 1) == 1);
      d     = $urandom;
      if (is_rd) begin
        last = model[w];
        issue(mk(Y, N, SW, N, 32'(w * 4), 32'h0, Y, N, N, last));
      end else begin
        model[w] = d;
        issue(mk(N, Y, SW, N, 32'(w * 4), d, N, N, N, last));
      end
      got = {rd_valid, mis, oor, rd_data};
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", k, got, e);
      end
    end
  endtask

  task automatic test_reset_mid_clear;
    logic [35:0] got;
    mem_rd64 = 1'b1;
    @(negedge clk); rst64 = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    n_checks++;
    if (rdy64 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_clear_ready: got %b expected 0", rdy64);
    end
    #1 rst64 = 1'b0;
    #1;
    got = {rdy64, rd_valid64, mis64, oor64, rd_data64};
    n_checks++;
    if (got !== 36'h0) begin
      n_fail++;
      $display("FAIL mid_clear_reset_values: got %h expected %h", got, 36'h0);
    end
    @(negedge clk); rst64 = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk); #1;
      got = {32'h0, rdy64, rd_valid64, mis64, oor64};
      n_checks++;
      if (got !== {32'h0, (i == 64), 3'b000}) begin
        n_fail++;
        $display("FAIL reclear_cycle_%0d: got %h expected %h", i, got, {32'h0, (i == 64), 3'b000});
      end
    end
    // The held load is accepted on the first cycle after clear completes.
    @(posedge clk); #1;
    got = {3'b000, rd_valid64, rd_data64};
    n_checks++;
    if (got !== {3'b000, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL post_clear_load: got %h expected %h", got, {3'b000, 1'b1, 32'h0});
    end
    mem_rd64 = 1'b0;
  endtask

  initial begin
    test_reset;
    test_clear_contents;
    test_subword;
    test_alignment;
    test_range;
    test_read_before_write;
    test_back_to_back;
    test_reset_mid_clear;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised data memory for the MEM stage of the pipelined MIPS datapath, successor to the fixed 32×32 word memory. Adds MIPS sub-word accesses (byte/half/word with sign or zero extension on loads), configurable depth, registered reads with a valid strobe, alignment and range checking, and a post-reset clear engine that stalls the pipeline through a `ready` output while memory is zeroed.

## Interface
Parameters:
- `DEPTH`, 256: number of 32-bit words; power of two, 4–4096.
- `CLEAR_ON_RESET`, 1: 1 = zero all words after reset via the clear engine; 0 = skip clearing, contents undefined.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `memRead`  in  1  load request.
- `memWrite`  in  1  store request.
- `size`  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- `unsignedLoad`  in  1  1 = zero-extend sub-word loads (lbu/lhu), 0 = sign-extend.
- `address`  in  32  byte address.
- `writeData`  in  32  store data; byte/half taken from bits [7:0]/[15:0].
- `readData`  out  32  load result, registered.
- `readValid`  out  1  one-cycle pulse: `readData` holds a new load result.
- `ready`  out  1  1 = block accepts requests; 0 during clear.
- `misaligned`  out  1  one-cycle pulse: previous request had an illegal alignment.
- `outOfRange`  out  1  one-cycle pulse: previous request addressed a word ≥ DEPTH.

## Operation
- Word index = `address[31:2]`; byte lane = `address[1:0]`, little-endian (lane 0 = bits [7:0]).
- States: CLEAR, RUN.
- Reset low (async): state ← CLEAR if `CLEAR_ON_RESET`, else RUN; clear counter ← 0; `readData` ← 0; `readValid`, `misaligned`, `outOfRange` ← 0; `ready` ← 0 when entering CLEAR, 1 when entering RUN.
- CLEAR: each cycle writes 0 to word[counter] and increments counter. After word DEPTH-1 is written, state ← RUN. Requests during CLEAR are ignored with no flags.
- RUN, request accepted when `memRead | memWrite`:
  - Alignment: half requires `address[0]`=0; word/11 requires `address[1:0]`=0. Violation → no write; `readData` holds its value; no `readValid`; `misaligned` pulses.
  - Range: word index ≥ DEPTH → no write; `readData` ← 0 and `readValid` pulses if read; `outOfRange` pulses. When both checks fail, misalignment takes priority and `outOfRange` stays 0.
  - Store: byte writes only the addressed lane; half writes lanes {1,0} or {3,2}; word writes all four. Other lanes are unchanged.
  - Load: selects the addressed byte/half/word and extends per `unsignedLoad`; word loads ignore `unsignedLoad`.
  - `memRead` and `memWrite` together at the same address: the write commits and the read returns the pre-write contents (read-before-write).
- Flags and `readValid` are 0 in every cycle without a qualifying event.

## Timing
- Load latency: 1 cycle. A request sampled at edge N updates `readData` and `readValid` after edge N; they are visible in cycle N+1.
- Store: commits at the sampling edge. A load at the same address in the next cycle returns the new data.
- `readData` persists until the next valid load, range-error load, or reset.
- Clear duration: exactly DEPTH cycles from the first rising edge after reset release. `ready` rises after the edge that writes word DEPTH-1.
- Reset asserted mid-clear or mid-access: immediate return to reset values. An in-flight store at that edge is not guaranteed to commit; clear restarts from word 0.
- Back-to-back requests are accepted every cycle in RUN, with no bubbles.

## Test plan
- Reset/clear (DEPTH=16): release reset → `ready`=0 for 16 cycles, then 1; lw at 0x3C → `readData`=0, `readValid` pulse.
- Sub-word store/load: sw 0x11223344 at 0x10; sb 0xAA at 0x11; lw 0x10 → 0x1122AA44; lb 0x11 → 0xFFFFFFAA; lbu 0x11 → 0x000000AA; lh 0x12 → 0x00001122.
- Alignment: lh 0x13 → `misaligned` pulse, no `readValid`, `readData` unchanged; sw 0x16 → memory unchanged.
- Range (DEPTH=16): sw at 0x40 → `outOfRange` pulse, word 0 unchanged; lw 0x40 → `readData`=0 with `readValid`. lh 0x41 → only `misaligned` pulses.
- Read-before-write: word 0x20=5; same-cycle read+write 9 at 0x20 → `readData`=5, next lw → 9.
- Reset mid-clear (DEPTH=64): assert reset at clear cycle 30, release → `ready` low 64 more cycles, all flags 0.
